// File: rtl/packet_assembler_pkg.sv
// Shared types and helpers for the packet assembler: FSM state encoding,
// frame geometry and the bit-serial CRC step used by the accumulator.
package PacketAssemblerPackage;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RECEIVE = 2'd1,
      HOLD    = 2'd2
   } state_t;

   localparam int unsigned CRC_MAX_W  = 64;
   localparam int unsigned DATA_MAX_W = 64;

   localparam int unsigned DEF_DATA_LENGTH    = 8;
   localparam int unsigned DEF_MESSAGE_LENGTH = 48;
   localparam int unsigned DEF_CRC_LENGTH     = 8;

   function automatic int unsigned seg_total(
      input int unsigned message_length,
      input int unsigned crc_length,
      input int unsigned data_length
   );
      return (message_length + crc_length) / data_length;
   endfunction

   localparam int unsigned SEG_TOTAL = seg_total(DEF_MESSAGE_LENGTH, DEF_CRC_LENGTH, DEF_DATA_LENGTH);
   localparam int unsigned SEG_BITS  = $clog2(SEG_TOTAL + 1);

   // MSB-first, non-reflected CRC step over one word. Operands are left-aligned
   // in fixed-size containers so the loop bound is a constant for synthesis.
   function automatic logic [CRC_MAX_W-1:0] crc_next(
      input logic [CRC_MAX_W-1:0]  crc,
      input logic [DATA_MAX_W-1:0] word,
      input logic [CRC_MAX_W-1:0]  poly,
      input int unsigned           crc_width,
      input int unsigned           data_width
   );
      logic [CRC_MAX_W-1:0]  acc;
      logic [CRC_MAX_W-1:0]  poly_al;
      logic [DATA_MAX_W-1:0] word_al;
      logic                  fb;
      acc     = crc  << (CRC_MAX_W - crc_width);
      poly_al = poly << (CRC_MAX_W - crc_width);
      word_al = word << (DATA_MAX_W - data_width);
      fb      = 1'b0;
      for (int unsigned i = 0; i < DATA_MAX_W; i++) begin
         if (i < data_width) begin
            fb      = acc[CRC_MAX_W-1] ^ word_al[DATA_MAX_W-1];
            acc     = acc << 1;
            word_al = word_al << 1;
            if (fb) begin
               acc = acc ^ poly_al;
            end
         end
      end
      return acc >> (CRC_MAX_W - crc_width);
   endfunction

endpackage

// File: rtl/packet_assembler_crc_accumulator.sv
// Running CRC register: restarts from CRC_INIT on clear and folds in one
// payload word per enabled cycle, so the result is ready with the last word.
module crc_accumulator
   import PacketAssemblerPackage::*;
#(
   parameter int unsigned            DATA_LENGTH = 8,
   parameter int unsigned            CRC_LENGTH  = 8,
   parameter logic [CRC_LENGTH-1:0]  CRC_POLY    = 8'h07,
   parameter logic [CRC_LENGTH-1:0]  CRC_INIT    = 8'h00
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_clear,
   input  logic                   i_enable,
   input  logic [DATA_LENGTH-1:0] i_data,
   output logic [CRC_LENGTH-1:0]  o_crc
);

   logic [CRC_LENGTH-1:0] r_crc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_crc <= CRC_INIT;
      end else if (i_clear) begin
         r_crc <= CRC_INIT;
      end else if (i_enable) begin
         r_crc <= CRC_LENGTH'(crc_next(CRC_MAX_W'(r_crc), DATA_MAX_W'(i_data),
                                       CRC_MAX_W'(CRC_POLY), CRC_LENGTH, DATA_LENGTH));
      end
   end

   assign o_crc = r_crc;

endmodule

// File: rtl/packet_assembler.sv
// Assembles SEG_TOTAL received words into payload + CRC, checks the CRC on the
// final word, drops stalled partial packets and hands good messages downstream.
module packet_assembler
   import PacketAssemblerPackage::*;
#(
   parameter int unsigned            DATA_LENGTH    = 8,
   parameter int unsigned            MESSAGE_LENGTH = 48,
   parameter int unsigned            CRC_LENGTH     = 8,
   parameter logic [CRC_LENGTH-1:0]  CRC_POLY       = 8'h07,
   parameter logic [CRC_LENGTH-1:0]  CRC_INIT       = 8'h00,
   parameter int unsigned            TIMEOUT_CYCLES = 100000,
   parameter int unsigned            COUNT_WIDTH    = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [DATA_LENGTH-1:0]    in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [MESSAGE_LENGTH-1:0] out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      crc_error,
   output logic                      timeout_error,
   output logic [COUNT_WIDTH-1:0]    good_count,
   output logic [COUNT_WIDTH-1:0]    error_count
);

   localparam int unsigned L_SEG_TOTAL    = seg_total(MESSAGE_LENGTH, CRC_LENGTH, DATA_LENGTH);
   localparam int unsigned L_PAYLOAD_SEGS = MESSAGE_LENGTH / DATA_LENGTH;
   localparam int unsigned L_SEG_BITS     = $clog2(L_SEG_TOTAL + 1);
   localparam int unsigned L_FRAME_BITS   = MESSAGE_LENGTH + CRC_LENGTH;
   localparam int unsigned L_HIST_BITS    = L_FRAME_BITS - DATA_LENGTH;
   localparam int unsigned L_TIMER_BITS   = $clog2(TIMEOUT_CYCLES + 1);

   state_t                     r_state;
   state_t                     w_state_next;
   logic [L_SEG_BITS-1:0]      r_seg_cnt;
   logic [L_HIST_BITS-1:0]     r_frame;
   logic [L_FRAME_BITS-1:0]    w_frame_next;
   logic [L_TIMER_BITS-1:0]    r_timer;
   logic [CRC_LENGTH-1:0]      w_crc;
   logic                       r_in_ready;
   logic [MESSAGE_LENGTH-1:0]  r_out_data;
   logic                       r_out_valid;
   logic                       r_crc_error;
   logic                       r_timeout_error;
   logic [COUNT_WIDTH-1:0]     r_good_count;
   logic [COUNT_WIDTH-1:0]     r_error_count;

   logic w_accept;
   logic w_last_word;
   logic w_payload_word;
   logic w_crc_ok;
   logic w_good_pkt;
   logic w_bad_pkt;
   logic w_timeout;
   logic w_crc_clear;

   // The buffer keeps only the earlier words; the final word is merged
   // combinationally so the CRC verdict lands on the accepting edge.
   assign w_frame_next   = {in_data, r_frame};
   assign w_accept       = in_valid & r_in_ready;
   assign w_last_word    = w_accept && (r_state == RECEIVE)
                           && (r_seg_cnt == L_SEG_BITS'(L_SEG_TOTAL - 1));
   assign w_payload_word = w_accept && (r_seg_cnt < L_SEG_BITS'(L_PAYLOAD_SEGS));
   assign w_crc_ok       = (w_frame_next[MESSAGE_LENGTH +: CRC_LENGTH] == w_crc);
   assign w_good_pkt     = w_last_word & w_crc_ok;
   assign w_bad_pkt      = w_last_word & ~w_crc_ok;
   assign w_timeout      = (r_state == RECEIVE) && !w_accept
                           && (r_timer == L_TIMER_BITS'(TIMEOUT_CYCLES - 1));
   assign w_crc_clear    = (w_state_next == IDLE);

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_next = RECEIVE;
            end
         end
         RECEIVE: begin
            if (w_good_pkt) begin
               w_state_next = HOLD;
            end else if (w_bad_pkt || w_timeout) begin
               w_state_next = IDLE;
            end
         end
         HOLD: begin
            if (out_ready) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   crc_accumulator #(
      .DATA_LENGTH (DATA_LENGTH),
      .CRC_LENGTH  (CRC_LENGTH),
      .CRC_POLY    (CRC_POLY),
      .CRC_INIT    (CRC_INIT)
   ) u_crc (
      .clk      (clk),
      .reset    (reset),
      .i_clear  (w_crc_clear),
      .i_enable (w_payload_word),
      .i_data   (in_data),
      .o_crc    (w_crc)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_in_ready <= 1'b0;
         r_seg_cnt  <= '0;
         r_frame    <= '0;
         r_timer    <= '0;
      end else begin
         r_state    <= w_state_next;
         r_in_ready <= (w_state_next != HOLD);
         if (w_state_next == IDLE) begin
            r_seg_cnt <= '0;
         end else if (w_accept) begin
            r_seg_cnt <= r_seg_cnt + 1'b1;
         end
         if (w_accept) begin
            r_frame <= w_frame_next[L_FRAME_BITS-1:DATA_LENGTH];
         end
         if (w_accept || (r_state != RECEIVE) || w_timeout) begin
            r_timer <= '0;
         end else begin
            r_timer <= r_timer + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out_data      <= '0;
         r_out_valid     <= 1'b0;
         r_crc_error     <= 1'b0;
         r_timeout_error <= 1'b0;
      end else begin
         r_crc_error     <= w_bad_pkt;
         r_timeout_error <= w_timeout;
         if (w_good_pkt) begin
            r_out_data  <= w_frame_next[MESSAGE_LENGTH-1:0];
            r_out_valid <= 1'b1;
         end else if ((r_state == HOLD) && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_good_count  <= '0;
         r_error_count <= '0;
      end else begin
         if (w_good_pkt && (r_good_count != '1)) begin
            r_good_count <= r_good_count + 1'b1;
         end
         if ((w_bad_pkt || w_timeout) && (r_error_count != '1)) begin
            r_error_count <= r_error_count + 1'b1;
         end
      end
   end

   assign in_ready      = r_in_ready;
   assign out_data      = r_out_data;
   assign out_valid     = r_out_valid;
   assign crc_error     = r_crc_error;
   assign timeout_error = r_timeout_error;
   assign good_count    = r_good_count;
   assign error_count   = r_error_count;

endmodule
